// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline control logic.
package pipeline_ctrl_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } hazard_ctrl_state;

    // Must match the jump predictor's NOP count after a mispredict.
    localparam int DEFAULT_FLUSH_CYCLES = 2;

endpackage : pipeline_ctrl_pkg

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;

    // Count events, holding at all-ones instead of wrapping.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule : sat_counter

// File: rtl/hazard_flush_controller.sv
// Pipeline sequencer: merges mispredict, load-use and memory-busy hazards
// into per-stage enables, flushes and PC redirect, plus perf counters.
module hazard_flush_controller
    import pipeline_ctrl_pkg::*;
#(
    parameter int PC_SIZE      = 12,
    parameter int FLUSH_CYCLES = DEFAULT_FLUSH_CYCLES,
    parameter int CNT_W        = 16
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               mispredict,
    input  logic [PC_SIZE-1:0] correct_pc,
    input  logic               load_use_hazard,
    input  logic               mem_busy,
    input  logic               counters_clear,
    output logic               pc_en,
    output logic               if_id_en,
    output logic               id_ex_en,
    output logic               if_id_flush,
    output logic               id_ex_flush,
    output logic               redirect,
    output logic [PC_SIZE-1:0] redirect_pc,
    output logic               busy,
    output logic [CNT_W-1:0]   mispredict_count,
    output logic [CNT_W-1:0]   stall_count
);

    // Remaining FLUSH-state cycles after the detection cycle, minus one.
    localparam logic [1:0] FLUSH_INIT = 2'(FLUSH_CYCLES - 2);

    hazard_ctrl_state r_state;
    hazard_ctrl_state w_state_next;
    logic [1:0]       r_flush_cnt;
    logic [1:0]       w_flush_cnt_next;
    logic             w_misp_inc;
    logic             w_stall_inc;

    // State and flush down-counter register.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state     <= RUN;
            r_flush_cnt <= '0;
        end else begin
            r_state     <= w_state_next;
            r_flush_cnt <= w_flush_cnt_next;
        end
    end

    // Next-state and zero-latency control outputs; mem_busy freezes everything.
    always_comb begin
        w_state_next     = r_state;
        w_flush_cnt_next = r_flush_cnt;
        w_misp_inc       = 1'b0;
        w_stall_inc      = 1'b0;
        pc_en            = 1'b1;
        if_id_en         = 1'b1;
        id_ex_en         = 1'b1;
        if_id_flush      = 1'b0;
        id_ex_flush      = 1'b0;
        redirect         = 1'b0;
        redirect_pc      = correct_pc;
        busy             = 1'b0;

        if (RESET) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_en    = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            redirect_pc = '0;
        end else if (mem_busy) begin
            pc_en    = 1'b0;
            if_id_en = 1'b0;
            id_ex_en = 1'b0;
            busy     = 1'b1;
        end else begin
            case (r_state)
                RUN: begin
                    if (mispredict) begin
                        redirect    = 1'b1;
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                        busy        = 1'b1;
                        w_misp_inc  = 1'b1;
                        if (FLUSH_CYCLES > 1) begin
                            w_state_next     = FLUSH;
                            w_flush_cnt_next = FLUSH_INIT;
                        end
                    end else if (load_use_hazard) begin
                        pc_en       = 1'b0;
                        if_id_en    = 1'b0;
                        id_ex_flush = 1'b1;
                        busy        = 1'b1;
                        w_stall_inc = 1'b1;
                    end
                end
                FLUSH: begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    busy        = 1'b1;
                    if (r_flush_cnt == 2'd0) begin
                        w_state_next = RUN;
                    end else begin
                        w_flush_cnt_next = r_flush_cnt - 2'd1;
                    end
                end
                default: begin
                    w_state_next = RUN;
                end
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_misp_cnt (
        .CLK   (CLK),
        .RESET (RESET),
        .clear (counters_clear),
        .inc   (w_misp_inc),
        .count (mispredict_count)
    );

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .CLK   (CLK),
        .RESET (RESET),
        .clear (counters_clear),
        .inc   (w_stall_inc),
        .count (stall_count)
    );

endmodule : hazard_flush_controller

// File: tb/tb_hazard_flush_controller.sv
// Scoreboard bench for hazard_flush_controller with directed vectors.
module tb_hazard_flush_controller;

    localparam int PC_SIZE = 12;
    localparam int CNT_W   = 2;

    // Control vector order: {pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush, redirect, busy}
    localparam logic [6:0] C_RST    = 7'b0001100;
    localparam logic [6:0] C_IDLE   = 7'b1110000;
    localparam logic [6:0] C_MISP   = 7'b1111111;
    localparam logic [6:0] C_FLSH   = 7'b1111101;
    localparam logic [6:0] C_STALL  = 7'b0010101;
    localparam logic [6:0] C_FREEZE = 7'b0000001;

    typedef struct {
        int unsigned        step;
        logic [6:0]         ctl;
        logic [PC_SIZE-1:0] rpc;
        logic [CNT_W-1:0]   mcnt;
        logic [CNT_W-1:0]   scnt;
    } exp_t;

    logic               CLK = 1'b0;
    logic               RESET = 1'b1;
    logic               mispredict = 1'b0;
    logic [PC_SIZE-1:0] correct_pc = '0;
    logic               load_use_hazard = 1'b0;
    logic               mem_busy = 1'b0;
    logic               counters_clear = 1'b0;
    logic               pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush;
    logic               redirect, busy;
    logic [PC_SIZE-1:0] redirect_pc;
    logic [CNT_W-1:0]   mispredict_count, stall_count;

    exp_t        sb[$];
    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int unsigned step_no = 0;

    hazard_flush_controller #(
        .PC_SIZE      (PC_SIZE),
        .FLUSH_CYCLES (2),
        .CNT_W        (CNT_W)
    ) dut (
        .CLK              (CLK),
        .RESET            (RESET),
        .mispredict       (mispredict),
        .correct_pc       (correct_pc),
        .load_use_hazard  (load_use_hazard),
        .mem_busy         (mem_busy),
        .counters_clear   (counters_clear),
        .pc_en            (pc_en),
        .if_id_en         (if_id_en),
        .id_ex_en         (id_ex_en),
        .if_id_flush      (if_id_flush),
        .id_ex_flush      (id_ex_flush),
        .redirect         (redirect),
        .redirect_pc      (redirect_pc),
        .busy             (busy),
        .mispredict_count (mispredict_count),
        .stall_count      (stall_count)
    );

    always #5 CLK = ~CLK;

    // Drive one cycle of inputs just after the rising edge and queue the expectation.
    task automatic step(input logic rst, input logic mp, input logic [PC_SIZE-1:0] cpc,
                        input logic lu, input logic mb, input logic clr,
                        input logic [6:0] ctl, input logic [PC_SIZE-1:0] rpc,
                        input logic [CNT_W-1:0] mc, input logic [CNT_W-1:0] sc);
        exp_t e;
        @(posedge CLK);
        #1;
        RESET           = rst;
        mispredict      = mp;
        correct_pc      = cpc;
        load_use_hazard = lu;
        mem_busy        = mb;
        counters_clear  = clr;
        step_no++;
        e.step = step_no;
        e.ctl  = ctl;
        e.rpc  = rpc;
        e.mcnt = mc;
        e.scnt = sc;
        sb.push_back(e);
    endtask

    // Monitor: outputs are valid every cycle, so pop and compare at each falling edge.
    initial begin
        exp_t       e;
        logic [6:0] act;
        forever begin
            @(negedge CLK);
            if (sb.size() > 0) begin
                e   = sb.pop_front();
                act = {pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush, redirect, busy};
                n_tests++;
                if (act !== e.ctl) begin
                    n_fail++;
                    $display("FAIL step%0d ctl: got %b expected %b", e.step, act, e.ctl);
                end
                n_tests++;
                if (redirect_pc !== e.rpc) begin
                    n_fail++;
                    $display("FAIL step%0d redirect_pc: got %h expected %h", e.step, redirect_pc, e.rpc);
                end
                n_tests++;
                if (mispredict_count !== e.mcnt) begin
                    n_fail++;
                    $display("FAIL step%0d mispredict_count: got %0d expected %0d", e.step, mispredict_count, e.mcnt);
                end
                n_tests++;
                if (stall_count !== e.scnt) begin
                    n_fail++;
                    $display("FAIL step%0d stall_count: got %0d expected %0d", e.step, stall_count, e.scnt);
                end
            end
        end
    end

    initial begin
        int unsigned wait_cycles;
        //    rst  mp   cpc      lu   mb   clr   ctl       rpc      mc  sc
        step(1'b1, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, C_RST,    12'h000, 0, 0); // 1 reset
        step(1'b0, 1'b0, 12'h055, 1'b0, 1'b0, 1'b0, C_IDLE,   12'h055, 0, 0); // 2 idle
        step(1'b0, 1'b1, 12'h1A4, 1'b0, 1'b0, 1'b0, C_MISP,   12'h1A4, 0, 0); // 3 mispredict
        step(1'b0, 1'b0, 12'h1A4, 1'b0, 1'b0, 1'b0, C_FLSH,   12'h1A4, 1, 0); // 4 flush
        step(1'b0, 1'b0, 12'h1A4, 1'b0, 1'b0, 1'b0, C_IDLE,   12'h1A4, 1, 0); // 5 back to run
        step(1'b0, 1'b0, 12'h010, 1'b1, 1'b0, 1'b0, C_STALL,  12'h010, 1, 0); // 6 load-use
        step(1'b0, 1'b0, 12'h010, 1'b1, 1'b0, 1'b0, C_STALL,  12'h010, 1, 1); // 7 load-use
        step(1'b0, 1'b0, 12'h010, 1'b0, 1'b0, 1'b0, C_IDLE,   12'h010, 1, 2); // 8 idle
        step(1'b0, 1'b1, 12'h2F0, 1'b1, 1'b0, 1'b0, C_MISP,   12'h2F0, 1, 2); // 9 mp + lu
        step(1'b0, 1'b0, 12'h2F0, 1'b1, 1'b0, 1'b0, C_FLSH,   12'h2F0, 2, 2); // 10 lu ignored in flush
        step(1'b0, 1'b0, 12'h2F0, 1'b0, 1'b0, 1'b0, C_IDLE,   12'h2F0, 2, 2); // 11
        step(1'b0, 1'b1, 12'h300, 1'b0, 1'b0, 1'b0, C_MISP,   12'h300, 2, 2); // 12 mispredict
        step(1'b0, 1'b0, 12'h300, 1'b0, 1'b1, 1'b0, C_FREEZE, 12'h300, 3, 2); // 13 freeze in flush
        step(1'b0, 1'b1, 12'h300, 1'b1, 1'b1, 1'b0, C_FREEZE, 12'h300, 3, 2); // 14 freeze, hazards ignored
        step(1'b0, 1'b0, 12'h300, 1'b0, 1'b1, 1'b0, C_FREEZE, 12'h300, 3, 2); // 15 freeze
        step(1'b0, 1'b0, 12'h300, 1'b0, 1'b0, 1'b0, C_FLSH,   12'h300, 3, 2); // 16 remaining flush
        step(1'b0, 1'b0, 12'h300, 1'b0, 1'b0, 1'b0, C_IDLE,   12'h300, 3, 2); // 17
        step(1'b0, 1'b1, 12'h040, 1'b0, 1'b0, 1'b0, C_MISP,   12'h040, 3, 2); // 18 4th mispredict
        step(1'b0, 1'b0, 12'h040, 1'b0, 1'b0, 1'b0, C_FLSH,   12'h040, 3, 2); // 19 saturated
        step(1'b0, 1'b1, 12'h080, 1'b0, 1'b0, 1'b0, C_MISP,   12'h080, 3, 2); // 20 5th mispredict
        step(1'b0, 1'b0, 12'h080, 1'b0, 1'b0, 1'b0, C_FLSH,   12'h080, 3, 2); // 21
        step(1'b0, 1'b0, 12'h080, 1'b0, 1'b0, 1'b0, C_IDLE,   12'h080, 3, 2); // 22
        step(1'b0, 1'b1, 12'h0C0, 1'b0, 1'b0, 1'b1, C_MISP,   12'h0C0, 3, 2); // 23 clear + mispredict
        step(1'b0, 1'b0, 12'h0C0, 1'b0, 1'b0, 1'b0, C_FLSH,   12'h0C0, 0, 0); // 24 cleared
        step(1'b0, 1'b0, 12'h0C0, 1'b0, 1'b0, 1'b0, C_IDLE,   12'h0C0, 0, 0); // 25
        step(1'b0, 1'b1, 12'h222, 1'b1, 1'b1, 1'b0, C_FREEZE, 12'h222, 0, 0); // 26 busy beats all in RUN
        step(1'b0, 1'b0, 12'h222, 1'b0, 1'b0, 1'b0, C_IDLE,   12'h222, 0, 0); // 27 nothing counted
        step(1'b0, 1'b0, 12'h005, 1'b1, 1'b0, 1'b0, C_STALL,  12'h005, 0, 0); // 28
        step(1'b0, 1'b0, 12'h005, 1'b1, 1'b0, 1'b0, C_STALL,  12'h005, 0, 1); // 29
        step(1'b0, 1'b0, 12'h005, 1'b1, 1'b0, 1'b0, C_STALL,  12'h005, 0, 2); // 30
        step(1'b0, 1'b0, 12'h005, 1'b1, 1'b0, 1'b0, C_STALL,  12'h005, 0, 3); // 31 saturating
        step(1'b0, 1'b0, 12'h005, 1'b0, 1'b0, 1'b0, C_IDLE,   12'h005, 0, 3); // 32 stall held at 3
        step(1'b0, 1'b1, 12'h0AB, 1'b0, 1'b0, 1'b0, C_MISP,   12'h0AB, 0, 3); // 33 mispredict
        step(1'b1, 1'b0, 12'h0AB, 1'b0, 1'b0, 1'b0, C_RST,    12'h000, 0, 0); // 34 reset mid-flush
        step(1'b0, 1'b0, 12'h111, 1'b0, 1'b0, 1'b0, C_IDLE,   12'h111, 0, 0); // 35 straight to RUN

        wait_cycles = 0;
        while (sb.size() > 0 && wait_cycles < 10) begin
            @(posedge CLK);
            wait_cycles++;
        end
        @(posedge CLK);
        if (sb.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_hazard_flush_controller

// File: doc/hazard_flush_controller.md
Name: hazard_flush_controller

Overview:
- Central pipeline sequencer for the 5-stage pipelined core.
- Combines three hazard sources into per-stage write-enable, flush and PC-redirect controls:
  - branch/jump mispredict, reported by the jump predictor at EX resolution;
  - load-use hazard, from the ID-stage detector;
  - data-memory busy.
- Sits between the risk-detection logic and the PC, IF/ID and ID/EX pipeline registers.
- Keeps saturating performance counters for mispredicts and load-use stalls.

Parameters:
- PC_SIZE, 12, width of instruction addresses.
- FLUSH_CYCLES, 2, bubble cycles inserted after a mispredict, counting the detection cycle. Legal range 1..3.
- CNT_W, 16, width of each performance counter.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- mispredict  in  1  EX-stage branch resolution disagrees with the prediction.
- correct_pc  in  PC_SIZE  PC to fetch after a mispredict; valid when mispredict=1.
- load_use_hazard  in  1  ID instruction needs the result of the EX-stage load.
- mem_busy  in  1  data memory not ready; freezes the whole pipeline.
- counters_clear  in  1  synchronous clear of both performance counters.
- pc_en  out  1  PC register write enable.
- if_id_en  out  1  IF/ID register write enable.
- id_ex_en  out  1  ID/EX register write enable.
- if_id_flush  out  1  load NOP into IF/ID.
- id_ex_flush  out  1  load NOP into ID/EX.
- redirect  out  1  select redirect_pc as the next PC.
- redirect_pc  out  PC_SIZE  redirect target.
- busy  out  1  controller is currently stalling, flushing or frozen.
- mispredict_count  out  CNT_W  saturating count of accepted mispredicts.
- stall_count  out  CNT_W  saturating count of load-use stall cycles.

Behaviour:
- Interface: one clock, CLK. Reset is asynchronous and active-high, port RESET.
- State register: RUN / FLUSH. Down-counter flush_cnt is 2 bits wide.
- Reset values:
  - state=RUN, flush_cnt=0, both counters=0.
  - While RESET=1, outputs are forced to: pc_en=0, if_id_en=0, id_ex_en=0, if_id_flush=1, id_ex_flush=1, redirect=0, redirect_pc=0, busy=0.
- All control outputs are combinational from state, flush_cnt and the current inputs (zero latency). Counters are registered and update at the next edge.
- Default outputs (RUN, no hazard): all en=1, both flush=0, redirect=0, redirect_pc=correct_pc, busy=0.
- Priority in RUN: mem_busy > mispredict > load_use_hazard.
- mem_busy=1, any state:
  - all en=0, both flush=0, redirect=0, busy=1;
  - state, flush_cnt and counters hold;
  - mispredict and load_use_hazard are ignored. EX/ID hold them stable because the pipeline is frozen.
- RUN with mispredict=1:
  - redirect=1, redirect_pc=correct_pc, pc_en=1, if_id_flush=1, id_ex_flush=1, busy=1;
  - mispredict_count increments.
  - If FLUSH_CYCLES>1: next state=FLUSH, flush_cnt<=FLUSH_CYCLES-2. Otherwise stay in RUN.
- RUN with load_use_hazard=1 (and no mispredict):
  - pc_en=0, if_id_en=0, id_ex_flush=1 (bubble), busy=1;
  - stall_count increments; stays in RUN.
  - Another stall follows for every cycle the hazard remains high.
- FLUSH:
  - pc_en=1, if_id_flush=1, id_ex_flush=1, redirect=0, busy=1;
  - mispredict and load_use_hazard are ignored, since they come from squashed instructions.
  - flush_cnt=0 gives next state RUN; otherwise flush_cnt decrements.
- Counters saturate at all-ones with no wrap.
- counters_clear has priority over increment: cleared value 0, and the same-cycle event is not counted.
- RESET asserted mid-FLUSH: immediate return to RUN with flush_cnt=0. Any pending redirect is lost; the predictor re-resolves.
- mispredict and load_use_hazard together in RUN: the mispredict wins, and stall_count does not increment.

Decomposition:
- Shared package pipeline_ctrl_pkg, containing:
  - typedef enum logic {RUN, FLUSH} hazard_ctrl_state;
  - localparam DEFAULT_FLUSH_CYCLES=2, which must match the predictor's nop count.
- Sub-module sat_counter #(W): CLK, RESET, clear, inc, count. Instantiated twice.

Test Plan:
- Reset: RESET=1 mid-operation -> en all 0, both flush=1, counters 0. After release, idle inputs -> pc_en=if_id_en=id_ex_en=1, busy=0.
- Mispredict, FLUSH_CYCLES=2, correct_pc=0x1A4:
  - cycle 0 -> redirect=1, redirect_pc=0x1A4, both flush=1;
  - cycle 1 -> both flush=1, redirect=0;
  - cycle 2 -> RUN defaults; mispredict_count=1.
- load_use_hazard high for 2 cycles -> pc_en=if_id_en=0 and id_ex_flush=1 for exactly 2 cycles; stall_count=2.
- mispredict and load_use_hazard together -> redirect path taken, stall_count unchanged. A load_use_hazard during the following FLUSH cycle is ignored.
- mem_busy=1 for 3 cycles in the middle of FLUSH -> all en=0 and flush=0 for 3 cycles. The remaining flush cycle completes afterwards, and total flush cycles still equal 2.
- Counter saturation with CNT_W=2: 5 mispredicts -> count stays at 3. counters_clear together with a mispredict -> count=0.
